// File: rtl/gtx_block_lock_ctrl.sv
// 64b/66b block-lock controller for one GTX RX lane: slips the gearbox until
// sync headers line up, then reports block lock and watches for lock loss.
module gtx_block_lock_ctrl #(
  parameter int unsigned SH_CNT_MAX       = 64,
  parameter int unsigned SH_INVALID_MAX   = 16,
  parameter int unsigned SLIP_WAIT_CYCLES = 32,
  parameter int unsigned SLIP_COUNT_WIDTH = 16
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [1:0]                  i_rxheader,
  input  logic                        i_rxheader_valid,
  output logic                        o_rxslip,
  output logic                        o_block_lock,
  output logic [1:0]                  o_state,
  output logic [SLIP_COUNT_WIDTH-1:0] o_slip_count
);

  // state     | meaning
  // TEST      | counting headers in the current test window
  // SLIP      | rxslip pulse is out, window counters cleared
  // SLIP_WAIT | gearbox settling after a slip, headers ignored
  localparam logic [1:0] TEST      = 2'd0;
  localparam logic [1:0] SLIP      = 2'd1;
  localparam logic [1:0] SLIP_WAIT = 2'd2;

  localparam int unsigned CW = $clog2(SH_CNT_MAX + 1);
  localparam int unsigned IW = $clog2(SH_INVALID_MAX + 1);
  localparam int unsigned WW = (SLIP_WAIT_CYCLES > 1) ? $clog2(SLIP_WAIT_CYCLES) : 1;
  localparam int unsigned SW = SLIP_COUNT_WIDTH;

  localparam logic [CW-1:0] CNT_MAX   = CW'(SH_CNT_MAX);
  localparam logic [IW-1:0] INV_MAX   = IW'(SH_INVALID_MAX);
  localparam logic [WW-1:0] WAIT_LAST = WW'(SLIP_WAIT_CYCLES - 1);

  logic [1:0]    state_q, state_d;
  logic          lock_q, lock_d;
  logic          slip_q, slip_d;
  logic [CW-1:0] sh_cnt_q, sh_cnt_d;
  logic [IW-1:0] sh_inv_q, sh_inv_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [SW-1:0] slip_cnt_q, slip_cnt_d;

  logic          hdr_inv;
  logic [CW-1:0] n_cnt;
  logic [IW-1:0] n_inv;

  assign hdr_inv = (i_rxheader == 2'b00) || (i_rxheader == 2'b11);
  assign n_cnt   = sh_cnt_q + CW'(1);
  assign n_inv   = sh_inv_q + IW'(hdr_inv);

  always_comb begin
    state_d    = state_q;
    lock_d     = lock_q;
    slip_d     = 1'b0;
    sh_cnt_d   = sh_cnt_q;
    sh_inv_d   = sh_inv_q;
    wait_d     = wait_q;
    slip_cnt_d = slip_cnt_q;
    case (state_q)
      TEST: begin
        if (i_rxheader_valid) begin
          if (!lock_q && hdr_inv) begin
            state_d = SLIP;
            slip_d  = 1'b1;
          end else if (lock_q && (n_inv == INV_MAX)) begin
            state_d = SLIP;
            slip_d  = 1'b1;
            lock_d  = 1'b0;
          end else if (n_cnt == CNT_MAX) begin
            // Unlocked windows only get here with zero invalid headers.
            sh_cnt_d = '0;
            sh_inv_d = '0;
            lock_d   = 1'b1;
          end else begin
            sh_cnt_d = n_cnt;
            sh_inv_d = n_inv;
          end
        end
      end
      SLIP: begin
        sh_cnt_d = '0;
        sh_inv_d = '0;
        wait_d   = '0;
        state_d  = SLIP_WAIT;
        if (slip_cnt_q != {SW{1'b1}}) slip_cnt_d = slip_cnt_q + SW'(1);
      end
      SLIP_WAIT: begin
        if (wait_q == WAIT_LAST) begin
          state_d  = TEST;
          wait_d   = '0;
          sh_cnt_d = '0;
          sh_inv_d = '0;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      default: state_d = TEST;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= TEST;
      lock_q     <= 1'b0;
      slip_q     <= 1'b0;
      sh_cnt_q   <= '0;
      sh_inv_q   <= '0;
      wait_q     <= '0;
      slip_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      lock_q     <= lock_d;
      slip_q     <= slip_d;
      sh_cnt_q   <= sh_cnt_d;
      sh_inv_q   <= sh_inv_d;
      wait_q     <= wait_d;
      slip_cnt_q <= slip_cnt_d;
    end
  end

  assign o_rxslip     = slip_q;
  assign o_block_lock = lock_q;
  assign o_state      = state_q;
  assign o_slip_count = slip_cnt_q;

endmodule

// File: tb/tb_gtx_block_lock_ctrl.sv
// Directed bench for gtx_block_lock_ctrl; expected outputs are queued as each
// step is driven and checked after the edge. A second instance uses a 4-bit slip counter.
module tb_gtx_block_lock_ctrl;

  logic        clk = 1'b0;
  logic        rst, rst2;
  logic [1:0]  hdr;
  logic        hv;

  logic        slip1, lock1, slip2, lock2;
  logic [1:0]  st1, st2;
  logic [15:0] cnt1;
  logic [3:0]  cnt2;

  always #5 clk = ~clk;

  gtx_block_lock_ctrl dut1 (
    .i_clk(clk), .i_rst(rst), .i_rxheader(hdr), .i_rxheader_valid(hv),
    .o_rxslip(slip1), .o_block_lock(lock1), .o_state(st1), .o_slip_count(cnt1)
  );

  gtx_block_lock_ctrl #(.SLIP_COUNT_WIDTH(4)) dut2 (
    .i_clk(clk), .i_rst(rst2), .i_rxheader(hdr), .i_rxheader_valid(hv),
    .o_rxslip(slip2), .o_block_lock(lock2), .o_state(st2), .o_slip_count(cnt2)
  );

  typedef struct {
    string       tag;
    bit          sel;
    logic [19:0] v;
  } exp_t;

  exp_t sbq[$];
  int   ncmp = 0;
  int   nfail = 0;
  int   ecnt = 0;

  // Expected vector is {lock, rxslip, state, slip_count}.
  task automatic step(input logic [1:0] hh, input logic vv, input logic rr, input bit sel,
                      input logic el, input logic es, input logic [1:0] est, input int ec,
                      input string tag);
    exp_t        e;
    logic [19:0] obs;
    hdr = hh;
    hv  = vv;
    if (sel) rst2 = rr;
    else     rst  = rr;
    e.tag = tag;
    e.sel = sel;
    e.v   = {el, es, est, 16'(ec)};
    sbq.push_back(e);
    @(posedge clk);
    #1;
    e   = sbq.pop_front();
    obs = e.sel ? {lock2, slip2, st2, 12'd0, cnt2} : {lock1, slip1, st1, cnt1};
    ncmp++;
    assert (obs === e.v) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.v);
    end
  endtask

  // The SLIP cycle bumps the counter; then 32 settling cycles and one cycle
  // where TEST is re-entered, all with headers ignored.
  task automatic wait_seq(input logic [1:0] hh, input logic vv, input bit sel, input string tag);
    if (sel) ecnt = (ecnt < 15) ? ecnt + 1 : 15;
    else     ecnt = ecnt + 1;
    for (int k = 0; k < 32; k++)
      step(hh, vv, 1'b0, sel, 1'b0, 1'b0, 2'd2, ecnt, $sformatf("%s_wait%0d", tag, k));
    step(hh, vv, 1'b0, sel, 1'b0, 1'b0, 2'd0, ecnt, $sformatf("%s_reenter", tag));
  endtask

  initial begin
    rst  = 1'b1;
    rst2 = 1'b1;
    hdr  = 2'b00;
    hv   = 1'b0;

    // Reset and initial lock
    step(2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 0, "reset");
    for (int i = 1; i <= 64; i++)
      step(2'b01, 1'b1, 1'b0, 1'b0, (i == 64), 1'b0, 2'd0, 0, $sformatf("lock_%0d", i));

    // Unlocked slip on the 10th header, then relock
    step(2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 0, "reset2");
    ecnt = 0;
    for (int i = 1; i <= 9; i++)
      step(2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 0, $sformatf("pre_slip_%0d", i));
    step(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, ecnt, "slip_10th");
    wait_seq(2'b11, 1'b1, 1'b0, "ign11");
    for (int i = 1; i <= 64; i++)
      step(2'b01, 1'b1, 1'b0, 1'b0, (i == 64), 1'b0, 2'd0, ecnt, $sformatf("relock_%0d", i));

    // Locked: 15 invalid in one window holds lock
    for (int i = 1; i <= 64; i++)
      step(((i % 4 == 0) && (i <= 60)) ? ((i % 8 == 0) ? 2'b11 : 2'b00) : 2'b01, 1'b1, 1'b0, 1'b0,
           1'b1, 1'b0, 2'd0, ecnt, $sformatf("hold_%0d", i));
    // Next window: 16th invalid at sample 40 loses lock
    for (int i = 1; i <= 40; i++) begin
      if (i == 40)
        step(2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, ecnt, "loss_40");
      else
        step(((i % 2 == 0) && (i <= 30)) ? 2'b00 : 2'b10, 1'b1, 1'b0, 1'b0,
             1'b1, 1'b0, 2'd0, ecnt, $sformatf("win2_%0d", i));
    end
    wait_seq(2'b01, 1'b1, 1'b0, "loss");

    // Strobe toggling; invalid headers only while strobe low
    for (int i = 1; i <= 64; i++) begin
      step(2'b01, 1'b1, 1'b0, 1'b0, (i == 64), 1'b0, 2'd0, ecnt, $sformatf("tog_v_%0d", i));
      step(2'b00, 1'b0, 1'b0, 1'b0, (i == 64), 1'b0, 2'd0, ecnt, $sformatf("tog_n_%0d", i));
    end

    // Reset during SLIP_WAIT
    step(2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 0, "reset3");
    ecnt = 0;
    step(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 0, "slip_pre_rst");
    for (int k = 0; k < 10; k++)
      step(2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1, $sformatf("sw_pre_rst_%0d", k));
    step(2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 0, "rst_in_wait");
    step(2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 0, "after_rst");

    // 4-bit slip counter saturation with continuous invalid headers
    step(2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 0, "sat_reset");
    ecnt = 0;
    for (int p = 1; p <= 18; p++) begin
      step(2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1, ecnt, $sformatf("sat_pulse%0d", p));
      wait_seq(2'b00, 1'b1, 1'b1, $sformatf("sat%0d", p));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/gtx_block_lock_ctrl.md
Name: gtx_block_lock_ctrl

Overview:
- 64b/66b block-lock controller for one GTX receive lane in the 10G Ethernet receive path.
- Watches the 2-bit sync header and its valid strobe from the gt_wrapper lane.
- Drives the lane's rxslip input until 66-bit block alignment is found, then reports block lock.
- Follows the IEEE 802.3 Clause 49 lock state machine. Runs in the GTX RX user-clock domain.

Parameters:
- SH_CNT_MAX, 64: valid header samples per test window.
- SH_INVALID_MAX, 16: invalid headers within one window that cause lock loss while locked.
- SLIP_WAIT_CYCLES, 32: clock cycles to ignore headers after each rxslip pulse (GTX gearbox settling time). Must be >=1.
- SLIP_COUNT_WIDTH, 16: width of the saturating slip counter.

Ports:
- i_clk  input  1  RX user clock (rxout_clk domain).
- i_rst  input  1  Synchronous reset, active-high.
- i_rxheader  input  2  Sync header from GTX.
- i_rxheader_valid  input  1  i_rxheader is a valid sample this cycle.
- o_rxslip  output  1  One-cycle slip request to GTX.
- o_block_lock  output  1  Block lock achieved.
- o_state  output  2  Debug state: 0=TEST, 1=SLIP, 2=SLIP_WAIT.
- o_slip_count  output  SLIP_COUNT_WIDTH  Saturating count of rxslip pulses issued.

Behaviour:
- Reset (i_rst high at a clock edge): state=TEST; o_rxslip=0; o_block_lock=0; o_slip_count=0; sh_cnt=0; sh_invalid_cnt=0; wait counter=0. Reset takes priority over all other events in every state.
- Header classification: valid when i_rxheader is 2'b01 or 2'b10; invalid when it is 2'b00 or 2'b11. Samples with i_rxheader_valid low are ignored entirely.
- On each header event in TEST, compute n_cnt = sh_cnt+1 and n_inv = sh_invalid_cnt + (header invalid). Evaluate in this priority order:
  - (a) o_block_lock=0 and header invalid: go to SLIP.
  - (b) o_block_lock=1 and n_inv==SH_INVALID_MAX: go to SLIP. o_block_lock is cleared at the same edge.
  - (c) n_cnt==SH_CNT_MAX: clear both counters. If unlocked, set o_block_lock=1; this is only reachable with n_inv==0 because of (a). If locked, lock is held.
  - (d) Otherwise: sh_cnt<=n_cnt, sh_invalid_cnt<=n_inv.
- Lock latency: o_block_lock rises on the edge that samples the SH_CNT_MAX-th consecutive valid header, so it is visible the cycle after that header.
- Slip latency: o_rxslip and state=SLIP are registered on the edge that samples the triggering header, so they are visible the following cycle.
- SLIP state (one cycle):
  - o_rxslip=1; counters cleared.
  - o_slip_count increments, saturating at 2^SLIP_COUNT_WIDTH-1.
  - Next state: SLIP_WAIT with the wait counter at 0.
- SLIP_WAIT state:
  - o_rxslip=0; all headers ignored.
  - Wait counter increments each cycle.
  - After SLIP_WAIT_CYCLES cycles in SLIP_WAIT, return to TEST with counters at 0.
- Pulse spacing: o_rxslip is never high on two consecutive cycles. Minimum spacing between pulses is SLIP_WAIT_CYCLES+2 cycles.
- The o_rxslip pulse is counted only when it is issued, so the saturated counter holds its value while further slips still occur.
- o_state reflects the current state register.

Test Plan:
- Reset, then 64 headers of 2'b01 with i_rxheader_valid continuously high: o_block_lock=1 from the cycle after the 64th; o_rxslip never asserted; o_slip_count=0.
- Unlocked, 2'b00 at the 10th header: o_rxslip high for exactly 1 cycle; o_slip_count=1. The next 32 cycles of 2'b11 headers cause no pulse. Then 64 valid headers give lock.
- Locked, a window with 15 invalid headers among 64: lock held. Next window, 16th invalid at sample 40: o_block_lock drops and o_rxslip pulses the cycle after sample 40.
- Valid headers with i_rxheader_valid toggling 1/0, and 2'b00 presented only while valid=0: lock after exactly 64 valid-strobe samples; no slip.
- Assert i_rst for 1 cycle at wait cycle 10 of SLIP_WAIT: the next cycle shows o_state=0, o_rxslip=0, o_block_lock=0, o_slip_count=0.
- SLIP_COUNT_WIDTH=4, continuous 2'b00 headers: o_slip_count reaches 15 and holds; pulses continue every 34 cycles.
